bullet_engine: RTL and testbench

Sequential sprite stage that owns the single player bullet: it latches a fire request, launches the bullet from the player position on the next frame tick, advances it a fixed step per frame in the latched direction, retires it at the active-area edge, and paints it per pixel. Sits between the display timing generator / player controller and the RGB compositor; its three colour outputs are OR-merged with the map and player layers downstream, so they are all-zero wherever the bullet is not drawn.

---
 rtl/game_pkg.sv | 25 ++
 rtl/sprite_hit.sv | 31 +++
 rtl/bullet_engine.sv | 155 +++++++++++++++
 tb/tb_bullet_engine.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared game-layer types: bullet direction/state encodings and
// default coordinate and colour widths used by the sprite stages.
package game_pkg;

    localparam int COORD_W_DEF    = 10;
    localparam int COLOR_BITS_DEF = 24;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_RIGHT = 2'd1,
        DIR_DOWN  = 2'd2,
        DIR_LEFT  = 2'd3
    } dir_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARMED  = 2'd1,
        ST_FLYING = 2'd2
    } bullet_state_e;

    function automatic int chan_w(input int color_bits);
        return color_bits / 3;
    endfunction

endpackage

// File: rtl/sprite_hit.sv
// Combinational test of whether a pixel lies inside a SIZE x SIZE
// square anchored at its top-left corner; shared by sprite layers.
module sprite_hit
    import game_pkg::*;
#(
    parameter int COORD_W = COORD_W_DEF,
    parameter int SIZE    = 4
) (
    input  logic [COORD_W-1:0] rect_x_i,
    input  logic [COORD_W-1:0] rect_y_i,
    input  logic [COORD_W-1:0] pix_x_i,
    input  logic [COORD_W-1:0] pix_y_i,
    output logic               hit_o
);

    localparam logic [COORD_W:0] SZ = SIZE[COORD_W:0];

    logic [COORD_W:0] x_end;
    logic [COORD_W:0] y_end;
    logic             in_x;
    logic             in_y;

    // One extra bit so a sprite touching the far edge cannot wrap.
    assign x_end = {1'b0, rect_x_i} + SZ;
    assign y_end = {1'b0, rect_y_i} + SZ;

    assign in_x  = (pix_x_i >= rect_x_i) && ({1'b0, pix_x_i} < x_end);
    assign in_y  = (pix_y_i >= rect_y_i) && ({1'b0, pix_y_i} < y_end);
    assign hit_o = in_x && in_y;

endmodule

// File: rtl/bullet_engine.sv
// Single player bullet: arm on fire edge, launch and step on frame
// ticks, retire at the active-area edge, paint with one-cycle latency.
module bullet_engine
    import game_pkg::*;
#(
    parameter int                      COLOR_BITS   = COLOR_BITS_DEF,
    parameter int                      COORD_W      = COORD_W_DEF,
    parameter int                      H_ACTIVE     = 640,
    parameter int                      V_ACTIVE     = 480,
    parameter int                      BULLET_SIZE  = 4,
    parameter int                      BULLET_SPEED = 4,
    parameter logic [COLOR_BITS-1:0]   BULLET_COLOR = 24'h00FFFF
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       frame_tick_i,
    input  logic                       fire_i,
    input  logic [1:0]                 dir_i,
    input  logic [COORD_W-1:0]         player_x_i,
    input  logic [COORD_W-1:0]         player_y_i,
    input  logic [COORD_W-1:0]         pixel_x_i,
    input  logic [COORD_W-1:0]         pixel_y_i,
    input  logic                       display_enable_i,
    output logic [COLOR_BITS/3-1:0]    bullet_blue_o,
    output logic [COLOR_BITS/3-1:0]    bullet_green_o,
    output logic [COLOR_BITS/3-1:0]    bullet_red_o,
    output logic                       bullet_active_o
);

    localparam int CH    = COLOR_BITS / 3;
    localparam int X_LIM_I = H_ACTIVE - BULLET_SIZE;
    localparam int Y_LIM_I = V_ACTIVE - BULLET_SIZE;

    localparam logic [COORD_W:0] SPD   = BULLET_SPEED[COORD_W:0];
    localparam logic [COORD_W:0] X_LIM = X_LIM_I[COORD_W:0];
    localparam logic [COORD_W:0] Y_LIM = Y_LIM_I[COORD_W:0];

    bullet_state_e        state_q, state_d;
    dir_e                 dir_q, dir_d;
    logic [COORD_W-1:0]   bx_q, bx_d;
    logic [COORD_W-1:0]   by_q, by_d;
    logic                 fire_q;
    logic [CH-1:0]        red_q, red_d;
    logic [CH-1:0]        green_q, green_d;
    logic [CH-1:0]        blue_q, blue_d;

    logic                 fire_rise;
    logic                 exit_w;
    logic                 hit_w;
    logic [COORD_W:0]     bx_w;
    logic [COORD_W:0]     by_w;

    assign fire_rise = fire_i && !fire_q;
    assign bx_w      = {1'b0, bx_q};
    assign by_w      = {1'b0, by_q};

    always_comb begin
        exit_w = 1'b0;
        unique case (dir_q)
            DIR_UP:    exit_w = by_w < SPD;
            DIR_RIGHT: exit_w = (bx_w + SPD) > X_LIM;
            DIR_DOWN:  exit_w = (by_w + SPD) > Y_LIM;
            DIR_LEFT:  exit_w = bx_w < SPD;
            default:   exit_w = 1'b1;
        endcase
    end

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        bx_d    = bx_q;
        by_d    = by_q;
        unique case (state_q)
            ST_IDLE: begin
                if (fire_rise) begin
                    state_d = ST_ARMED;
                    dir_d   = dir_e'(dir_i);
                end
            end
            ST_ARMED: begin
                if (frame_tick_i) begin
                    bx_d    = player_x_i;
                    by_d    = player_y_i;
                    state_d = ST_FLYING;
                end
            end
            ST_FLYING: begin
                if (frame_tick_i) begin
                    if (exit_w) begin
                        state_d = ST_IDLE;
                    end else begin
                        unique case (dir_q)
                            DIR_UP:    by_d = by_q - SPD[COORD_W-1:0];
                            DIR_RIGHT: bx_d = bx_q + SPD[COORD_W-1:0];
                            DIR_DOWN:  by_d = by_q + SPD[COORD_W-1:0];
                            DIR_LEFT:  bx_d = bx_q - SPD[COORD_W-1:0];
                            default:   bx_d = bx_q;
                        endcase
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    sprite_hit #(
        .COORD_W (COORD_W),
        .SIZE    (BULLET_SIZE)
    ) u_hit (
        .rect_x_i (bx_q),
        .rect_y_i (by_q),
        .pix_x_i  (pixel_x_i),
        .pix_y_i  (pixel_y_i),
        .hit_o    (hit_w)
    );

    always_comb begin
        red_d   = '0;
        green_d = '0;
        blue_d  = '0;
        if ((state_q == ST_FLYING) && display_enable_i && hit_w) begin
            red_d   = BULLET_COLOR[CH-1:0];
            green_d = BULLET_COLOR[2*CH-1:CH];
            blue_d  = BULLET_COLOR[3*CH-1:2*CH];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            dir_q   <= DIR_UP;
            bx_q    <= '0;
            by_q    <= '0;
            fire_q  <= 1'b0;
            red_q   <= '0;
            green_q <= '0;
            blue_q  <= '0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            bx_q    <= bx_d;
            by_q    <= by_d;
            fire_q  <= fire_i;
            red_q   <= red_d;
            green_q <= green_d;
            blue_q  <= blue_d;
        end
    end

    assign bullet_red_o    = red_q;
    assign bullet_green_o  = green_q;
    assign bullet_blue_o   = blue_q;
    assign bullet_active_o = (state_q == ST_FLYING);

endmodule

// File: tb/tb_bullet_engine.sv
// Directed bench for bullet_engine: launch, flight, edge retire,
// fire-edge corner cases, display gating and asynchronous reset.
module tb_bullet_engine;

    logic       clk;
    logic       rst_n;
    logic       tick;
    logic       fire;
    logic [1:0] dir;
    logic [9:0] px_player, py_player;
    logic [9:0] pix_x, pix_y;
    logic       de;
    logic [7:0] blue, green, red;
    logic       active;

    int checks   = 0;
    int failures = 0;

    localparam logic [23:0] ON  = 24'h00FFFF;
    localparam logic [23:0] OFF = 24'h000000;

    bullet_engine dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .frame_tick_i     (tick),
        .fire_i           (fire),
        .dir_i            (dir),
        .player_x_i       (px_player),
        .player_y_i       (py_player),
        .pixel_x_i        (pix_x),
        .pixel_y_i        (pix_y),
        .display_enable_i (de),
        .bullet_blue_o    (blue),
        .bullet_green_o   (green),
        .bullet_red_o     (red),
        .bullet_active_o  (active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_tick();
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
    endtask

    task automatic probe(input string tag, input logic [9:0] x,
                         input logic [9:0] y, input logic en,
                         input logic [23:0] exp);
        pix_x = x;
        pix_y = y;
        de    = en;
        @(negedge clk);
        check(tag, {8'h0, blue, green, red}, {8'h0, exp});
        de = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        tick = 1'b0;
        fire = 1'b0;
        dir = 2'd0;
        px_player = '0;
        py_player = '0;
        pix_x = '0;
        pix_y = '0;
        de = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_colour", {8'h0, blue, green, red}, 32'h0);
        check("reset_active", {31'h0, active}, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Fire right from (100,50), held across launch and two more ticks.
        dir = 2'd1;
        px_player = 10'd100;
        py_player = 10'd50;
        fire = 1'b1;
        @(negedge clk);
        check("armed_not_active", {31'h0, active}, 32'h0);
        probe("armed_no_paint", 10'd101, 10'd51, 1'b1, OFF);
        do_tick();
        check("launch_active", {31'h0, active}, 32'h1);
        probe("launch_hit", 10'd101, 10'd51, 1'b1, ON);
        probe("launch_right_edge", 10'd104, 10'd51, 1'b1, OFF);
        probe("launch_corner", 10'd100, 10'd50, 1'b1, ON);
        probe("launch_left_out", 10'd99, 10'd50, 1'b1, OFF);
        do_tick();
        do_tick();
        check("held_one_launch", {31'h0, active}, 32'h1);
        probe("held_at_108", 10'd108, 10'd50, 1'b1, ON);
        probe("held_not_107", 10'd107, 10'd50, 1'b1, OFF);

        // Second press while flying must not relaunch from the player.
        fire = 1'b0;
        @(negedge clk);
        px_player = 10'd300;
        fire = 1'b1;
        @(negedge clk);
        fire = 1'b0;
        do_tick();
        do_tick();
        do_tick();
        probe("fly_at_120", 10'd120, 10'd50, 1'b1, ON);
        probe("fly_not_119", 10'd119, 10'd53, 1'b1, OFF);
        probe("fly_not_player", 10'd300, 10'd50, 1'b1, OFF);
        probe("de_low_inside", 10'd121, 10'd51, 1'b0, OFF);

        // Fly to the right limit: 120 + 129*4 = 636.
        for (int i = 0; i < 129; i++) do_tick();
        check("at_limit_active", {31'h0, active}, 32'h1);
        probe("at_636", 10'd636, 10'd50, 1'b1, ON);
        probe("at_639_53", 10'd639, 10'd53, 1'b1, ON);

        // Exit tick with a coincident fire edge: edge is lost.
        fire = 1'b1;
        do_tick();
        check("retired", {31'h0, active}, 32'h0);
        probe("retired_no_paint", 10'd636, 10'd50, 1'b1, OFF);
        do_tick();
        check("lost_edge_idle", {31'h0, active}, 32'h0);
        fire = 1'b0;
        @(negedge clk);

        // Fire edge coincident with a tick in IDLE: launch on next tick.
        dir = 2'd0;
        px_player = 10'd200;
        py_player = 10'd300;
        fire = 1'b1;
        do_tick();
        check("coincident_no_launch", {31'h0, active}, 32'h0);
        dir = 2'd2;
        do_tick();
        check("coincident_launch", {31'h0, active}, 32'h1);
        probe("up_launch_pos", 10'd200, 10'd300, 1'b1, ON);
        do_tick();
        probe("up_at_296", 10'd200, 10'd296, 1'b1, ON);
        probe("up_not_300", 10'd200, 10'd300, 1'b1, OFF);

        // Asynchronous reset mid-flight, between clock edges.
        pix_x = 10'd201;
        pix_y = 10'd297;
        de = 1'b1;
        @(negedge clk);
        check("pre_reset_paint", {8'h0, blue, green, red}, {8'h0, ON});
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_colour", {8'h0, blue, green, red}, 32'h0);
        check("async_rst_active", {31'h0, active}, 32'h0);
        de = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_idle", {31'h0, active}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
